// File: rtl/ex_mem_reg_if.sv
// EX->MEM pipeline register bundle: EX-side results, stall/flush controls,
// MEM-side registered copies and the MADD/MSUB loop back to EX.
// Ports (signals): stall_ex_i, stall_mem_i, flush_i, ex_wd_i, ex_wreg_i,
//   ex_wdata_i, ex_hi_i, ex_lo_i, ex_whilo_i, hilo_temp_i, cnt_i (EX -> reg);
//   mem_wd_o, mem_wreg_o, mem_wdata_o, mem_hi_o, mem_lo_o, mem_whilo_o,
//   mem_valid_o, hilo_temp_o, cnt_o (reg -> MEM/EX).
// Modports: master = EX/control side, slave = the register itself.
interface ex_mem_reg_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int HILO_W = 32
);
    logic                  stall_ex_i;
    logic                  stall_mem_i;
    logic                  flush_i;
    logic [ADDR_W-1:0]     ex_wd_i;
    logic                  ex_wreg_i;
    logic [DATA_W-1:0]     ex_wdata_i;
    logic [HILO_W-1:0]     ex_hi_i;
    logic [HILO_W-1:0]     ex_lo_i;
    logic                  ex_whilo_i;
    logic [2*HILO_W-1:0]   hilo_temp_i;
    logic [1:0]            cnt_i;

    logic [ADDR_W-1:0]     mem_wd_o;
    logic                  mem_wreg_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [HILO_W-1:0]     mem_hi_o;
    logic [HILO_W-1:0]     mem_lo_o;
    logic                  mem_whilo_o;
    logic                  mem_valid_o;
    logic [2*HILO_W-1:0]   hilo_temp_o;
    logic [1:0]            cnt_o;

    modport master (
        output stall_ex_i, stall_mem_i, flush_i,
        output ex_wd_i, ex_wreg_i, ex_wdata_i,
        output ex_hi_i, ex_lo_i, ex_whilo_i,
        output hilo_temp_i, cnt_i,
        input  mem_wd_o, mem_wreg_o, mem_wdata_o,
        input  mem_hi_o, mem_lo_o, mem_whilo_o,
        input  mem_valid_o, hilo_temp_o, cnt_o
    );

    modport slave (
        input  stall_ex_i, stall_mem_i, flush_i,
        input  ex_wd_i, ex_wreg_i, ex_wdata_i,
        input  ex_hi_i, ex_lo_i, ex_whilo_i,
        input  hilo_temp_i, cnt_i,
        output mem_wd_o, mem_wreg_o, mem_wdata_o,
        output mem_hi_o, mem_lo_o, mem_whilo_o,
        output mem_valid_o, hilo_temp_o, cnt_o
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall hold, bubble insert, flush and the
// optional MADD/MSUB partial-product loop (macro EX_MEM_MADD_EN).
// Ports: clk, rst (async, active-high), bus (ex_mem_reg_if.slave).
// Without EX_MEM_MADD_EN the loop outputs are tied to zero.
module ex_mem_reg #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int HILO_W = 32
) (
    input logic          clk,
    input logic          rst,
    ex_mem_reg_if.slave  bus
);

    // Main MEM-side slot. Stall_mem wins over stall_ex, so an illegal
    // stall_mem-only cycle simply holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush_i) begin
            bus.mem_wd_o    <= {ADDR_W{1'b0}};
            bus.mem_wreg_o  <= 1'b0;
            bus.mem_wdata_o <= {DATA_W{1'b0}};
            bus.mem_hi_o    <= {HILO_W{1'b0}};
            bus.mem_lo_o    <= {HILO_W{1'b0}};
            bus.mem_whilo_o <= 1'b0;
            bus.mem_valid_o <= 1'b0;
        end else if (bus.stall_mem_i) begin
            bus.mem_wd_o    <= bus.mem_wd_o;
            bus.mem_wreg_o  <= bus.mem_wreg_o;
            bus.mem_wdata_o <= bus.mem_wdata_o;
            bus.mem_hi_o    <= bus.mem_hi_o;
            bus.mem_lo_o    <= bus.mem_lo_o;
            bus.mem_whilo_o <= bus.mem_whilo_o;
            bus.mem_valid_o <= bus.mem_valid_o;
        end else if (bus.stall_ex_i) begin
            // Bubble: enables forced low so nothing stale commits.
            bus.mem_wd_o    <= {ADDR_W{1'b0}};
            bus.mem_wreg_o  <= 1'b0;
            bus.mem_wdata_o <= {DATA_W{1'b0}};
            bus.mem_hi_o    <= {HILO_W{1'b0}};
            bus.mem_lo_o    <= {HILO_W{1'b0}};
            bus.mem_whilo_o <= 1'b0;
            bus.mem_valid_o <= 1'b0;
        end else begin
            bus.mem_wd_o    <= bus.ex_wd_i;
            bus.mem_wreg_o  <= bus.ex_wreg_i;
            bus.mem_wdata_o <= bus.ex_wdata_i;
            bus.mem_hi_o    <= bus.ex_hi_i;
            bus.mem_lo_o    <= bus.ex_lo_i;
            bus.mem_whilo_o <= bus.ex_whilo_i;
            bus.mem_valid_o <= 1'b1;
        end
    end

`ifdef EX_MEM_MADD_EN
    // Loop carries the first-cycle product only while EX is stalled on it;
    // any advance clears it so the next MADD starts from cnt=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush_i) begin
            bus.hilo_temp_o <= {2*HILO_W{1'b0}};
            bus.cnt_o       <= 2'd0;
        end else if (bus.stall_mem_i) begin
            bus.hilo_temp_o <= bus.hilo_temp_o;
            bus.cnt_o       <= bus.cnt_o;
        end else if (bus.stall_ex_i) begin
            bus.hilo_temp_o <= bus.hilo_temp_i;
            bus.cnt_o       <= bus.cnt_i;
        end else begin
            bus.hilo_temp_o <= {2*HILO_W{1'b0}};
            bus.cnt_o       <= 2'd0;
        end
    end
`else
    assign bus.hilo_temp_o = {2*HILO_W{1'b0}};
    assign bus.cnt_o       = 2'd0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed steps plus random cycles
// checked against a rule-level reference model of the register slot.
module tb_ex_mem_reg;

`ifdef EX_MEM_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [63:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        valid;
        logic [63:0] ht;
        logic [1:0]  cnt;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    st_t  exp_s = '0;

    ex_mem_reg_if #(.ADDR_W(5), .DATA_W(64), .HILO_W(32)) bus ();

    ex_mem_reg #(.ADDR_W(5), .DATA_W(64), .HILO_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: what the slot must hold after one edge, given the
    // current inputs and the previous slot contents.
    function automatic st_t model_next(st_t cur);
        st_t n = '0;
        if (bus.flush_i) begin
            n = '0;
        end else if (bus.stall_mem_i) begin
            n = cur;
        end else if (bus.stall_ex_i) begin
            n.ht  = MADD ? bus.hilo_temp_i : 64'd0;
            n.cnt = MADD ? bus.cnt_i : 2'd0;
        end else begin
            n.wd    = bus.ex_wd_i;
            n.wreg  = bus.ex_wreg_i;
            n.wdata = bus.ex_wdata_i;
            n.hi    = bus.ex_hi_i;
            n.lo    = bus.ex_lo_i;
            n.whilo = bus.ex_whilo_i;
            n.valid = 1'b1;
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".wd"},    64'(bus.mem_wd_o),    64'(exp_s.wd));
        chk({tag, ".wreg"},  64'(bus.mem_wreg_o),  64'(exp_s.wreg));
        chk({tag, ".wdata"}, bus.mem_wdata_o,      exp_s.wdata);
        chk({tag, ".hi"},    64'(bus.mem_hi_o),    64'(exp_s.hi));
        chk({tag, ".lo"},    64'(bus.mem_lo_o),    64'(exp_s.lo));
        chk({tag, ".whilo"}, 64'(bus.mem_whilo_o), 64'(exp_s.whilo));
        chk({tag, ".valid"}, 64'(bus.mem_valid_o), 64'(exp_s.valid));
        chk({tag, ".ht"},    bus.hilo_temp_o,      exp_s.ht);
        chk({tag, ".cnt"},   64'(bus.cnt_o),       64'(exp_s.cnt));
    endtask

    task automatic drive(logic sx, logic sm, logic fl,
                         logic [4:0] wd, logic wr, logic [63:0] wdat,
                         logic [31:0] hi, logic [31:0] lo, logic wh,
                         logic [63:0] ht, logic [1:0] cnt);
        bus.stall_ex_i  = sx;
        bus.stall_mem_i = sm;
        bus.flush_i     = fl;
        bus.ex_wd_i     = wd;
        bus.ex_wreg_i   = wr;
        bus.ex_wdata_i  = wdat;
        bus.ex_hi_i     = hi;
        bus.ex_lo_i     = lo;
        bus.ex_whilo_i  = wh;
        bus.hilo_temp_i = ht;
        bus.cnt_i       = cnt;
    endtask

    task automatic step(string tag);
        st_t nxt;
        nxt = model_next(exp_s);
        @(posedge clk);
        #1;
        exp_s = nxt;
        check_all(tag);
    endtask

    task automatic drive_rand();
        logic sx, sm, fl;
        int r;
        r  = int'($urandom_range(0, 99));
        fl = (r < 6);
        sm = (r >= 6 && r < 20);
        sx = sm ? ($urandom_range(0, 9) != 0) : (r >= 20 && r < 45);
        drive(sx, sm, fl, 5'($urandom), 1'($urandom),
              {$urandom, $urandom}, $urandom, $urandom, 1'($urandom),
              {$urandom, $urandom}, 2'($urandom));
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 64'hDEAD_BEEF_0000_0001,
              32'h5, 32'h6, 1'b1, 64'h77, 2'd1);
        #2;
        exp_s = '0;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Load something, then reset asynchronously mid-cycle.
        drive(1'b0, 1'b0, 1'b0, 5'd17, 1'b1, 64'hCAFE, 32'h1, 32'h2,
              1'b1, 64'h0, 2'd0);
        step("preload");
        drive(1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 64'h1234, 32'h3, 32'h4,
              1'b1, 64'h99, 2'd1);
        #3;
        rst = 1'b1;
        #1;
        exp_s = '0;
        check_all("async_rst");
        #1;
        rst = 1'b0;

        // Advance.
        drive(1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 64'h1122334455667788,
              32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
        step("advance");
        chk("advance.lit_wd", 64'(bus.mem_wd_o), 64'd3);
        chk("advance.lit_wdata", bus.mem_wdata_o, 64'h1122334455667788);
        chk("advance.lit_valid", 64'(bus.mem_valid_o), 64'd1);

        // Full stall: hold regardless of changing inputs.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'(i + 20), 1'b0, 64'(i * 7 + 1),
                  32'(i), 32'(i + 9), 1'b1, 64'(i + 5), 2'(i));
            step("hold");
            chk("hold.lit_wdata", bus.mem_wdata_o, 64'h1122334455667788);
        end

        // Bubble with MADD first cycle.
        drive(1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 64'h55, 32'h7, 32'h8, 1'b1,
              64'hFFFF_0000_0000_0001, 2'd1);
        step("bubble");
        chk("bubble.lit_wreg", 64'(bus.mem_wreg_o), 64'd0);
        chk("bubble.lit_whilo", 64'(bus.mem_whilo_o), 64'd0);
        chk("bubble.lit_ht", bus.hilo_temp_o,
            MADD ? 64'hFFFF_0000_0000_0001 : 64'd0);
        chk("bubble.lit_cnt", 64'(bus.cnt_o), MADD ? 64'd1 : 64'd0);

        // MADD completes.
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0, 32'hA, 32'hB, 1'b1,
              64'h0, 2'd2);
        step("madd_done");
        chk("madd_done.lit_hi", 64'(bus.mem_hi_o), 64'hA);
        chk("madd_done.lit_cnt", 64'(bus.cnt_o), 64'd0);

        // Flush beats a MEM stall with the loop armed.
        drive(1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 64'h1, 32'h1, 32'h1, 1'b1,
              64'hABCD, 2'd1);
        step("arm");
        drive(1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 64'h2, 32'h2, 32'h2, 1'b1,
              64'h1, 2'd1);
        step("flush");
        chk("flush.lit_cnt", 64'(bus.cnt_o), 64'd0);

        // Illegal stall_mem without stall_ex: hold.
        drive(1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 64'h4242, 32'h3, 32'h4,
              1'b1, 64'h0, 2'd0);
        step("pre_illegal");
        drive(1'b0, 1'b1, 1'b0, 5'd13, 1'b0, 64'h0, 32'h0, 32'h0, 1'b0,
              64'h0, 2'd0);
        step("illegal_hold");

        // Random phase, with one async reset thrown in.
        for (int i = 0; i < 300; i++) begin
            drive_rand();
            if (i == 150) begin
                #3;
                rst = 1'b1;
                #1;
                exp_s = '0;
                check_all("rand_rst");
                #1;
                rst = 1'b0;
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
